branch_redirect: RTL and testbench

- Sits directly downstream of the NBRANCH branch units.
- Each cycle, collects their commit_br_* mispredict outputs and selects the oldest one relative to the commit-ring head.
- Holds that redirect in a single pending register and presents it to fetch over a valid/ready handshake.
- Replaces the held redirect when an older mispredict arrives, and drops it when commit_kill flushes its entry.

---
 rtl/branch_redirect_pkg.sv | 20 ++
 rtl/branch_redirect_pick.sv | 54 +++++
 rtl/branch_redirect.sv | 135 +++++++++++++
 tb/tb_branch_redirect.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_pkg.sv
// Shared types and helpers for the branch redirect block and its pickers.
package branch_redirect_pkg;

   // Redirect holding state: IDLE has nothing pending, PEND presents a redirect to fetch.
   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StPend = 1'b1
   } state_e;

   // Distance of a commit-ring index from the ring head; smaller is older.
   // Arguments are zero-extended ring indices; lncommit selects the ring size.
   function automatic logic [31:0] age_of(input logic [31:0] addr,
                                          input logic [31:0] start,
                                          input int unsigned lncommit);
      logic [31:0] mask;
      mask = (32'd1 << lncommit) - 32'd1;
      return (addr - start) & mask;
   endfunction

endpackage

// File: rtl/branch_redirect_pick.sv
// Combinational oldest-select across NBRANCH requesters, ordered by commit-ring age.
module branch_redirect_pick
   import branch_redirect_pkg::*;
#(
   parameter int unsigned NBRANCH  = 2,
   parameter int unsigned RV       = 64,
   parameter int unsigned NCOMMIT  = 32,
   parameter int unsigned LNCOMMIT = 5,
   parameter int unsigned BDEC     = 4,
   parameter int unsigned IDXW     = (NBRANCH > 1) ? $clog2(NBRANCH) : 1
) (
   input  logic [NBRANCH-1:0]            br_enable,
   input  logic [NBRANCH*(RV-1)-1:0]     br_pc,
   input  logic [NBRANCH*LNCOMMIT-1:0]   br_addr,
   input  logic [NBRANCH-1:0]            br_short,
   input  logic [NBRANCH*(BDEC-1)-1:0]   br_dec,
   input  logic [LNCOMMIT-1:0]           commit_start,
   input  logic [NCOMMIT-1:0]            commit_kill,
   output logic                          cand_v,
   output logic [IDXW-1:0]               cand_idx,
   output logic [LNCOMMIT-1:0]           cand_age,
   output logic [RV-2:0]                 cand_pc,
   output logic                          cand_short,
   output logic [BDEC-2:0]               cand_dec
);

   logic [LNCOMMIT-1:0] addr_i;
   logic [LNCOMMIT-1:0] age_i;

   // Linear scan; strict '<' keeps the lowest index on an (illegal) age tie.
   always_comb begin
      cand_v     = 1'b0;
      cand_idx   = '0;
      cand_age   = '0;
      cand_pc    = '0;
      cand_short = 1'b0;
      cand_dec   = '0;
      addr_i     = '0;
      age_i      = '0;
      for (int i = 0; i < NBRANCH; i++) begin
         addr_i = br_addr[i*LNCOMMIT +: LNCOMMIT];
         age_i  = LNCOMMIT'(age_of(32'(addr_i), 32'(commit_start), LNCOMMIT));
         if (br_enable[i] && !commit_kill[addr_i] && (!cand_v || (age_i < cand_age))) begin
            cand_v     = 1'b1;
            cand_idx   = IDXW'(i);
            cand_age   = age_i;
            cand_pc    = br_pc[i*(RV-1) +: (RV-1)];
            cand_short = br_short[i];
            cand_dec   = br_dec[i*(BDEC-1) +: (BDEC-1)];
         end
      end
   end

endmodule

// File: rtl/branch_redirect.sv
// Collects branch-unit mispredicts, keeps the oldest one pending and hands it to fetch.
module branch_redirect
   import branch_redirect_pkg::*;
#(
   parameter int unsigned NBRANCH  = 2,
   parameter int unsigned RV       = 64,
   parameter int unsigned NCOMMIT  = 32,
   parameter int unsigned LNCOMMIT = 5,
   parameter int unsigned BDEC     = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NBRANCH-1:0]            br_enable,
   input  logic [NBRANCH*(RV-1)-1:0]     br_pc,
   input  logic [NBRANCH*LNCOMMIT-1:0]   br_addr,
   input  logic [NBRANCH-1:0]            br_short,
   input  logic [NBRANCH*(BDEC-1)-1:0]   br_dec,
   input  logic [LNCOMMIT-1:0]           commit_start,
   input  logic [NCOMMIT-1:0]            commit_kill,
   input  logic                          redirect_ready,
   output logic                          redirect_valid,
   output logic [RV-2:0]                 redirect_pc,
   output logic [LNCOMMIT-1:0]           redirect_addr,
   output logic                          redirect_short,
   output logic [BDEC-2:0]               redirect_dec
);

   localparam int unsigned IDXW = (NBRANCH > 1) ? $clog2(NBRANCH) : 1;

   state_e              state_q, state_d;
   logic [RV-2:0]       pc_q;
   logic [LNCOMMIT-1:0] addr_q;
   logic                short_q;
   logic [BDEC-2:0]     dec_q;
   logic                load;

   logic                cand_v;
   logic [IDXW-1:0]     cand_idx;
   logic [LNCOMMIT-1:0] cand_age;
   logic [RV-2:0]       cand_pc;
   logic                cand_short;
   logic [BDEC-2:0]     cand_dec;
   logic [LNCOMMIT-1:0] cand_addr;
   logic [LNCOMMIT-1:0] held_age;
   logic                held_kill;
   logic                cand_older;

   branch_redirect_pick #(
      .NBRANCH  (NBRANCH),
      .RV       (RV),
      .NCOMMIT  (NCOMMIT),
      .LNCOMMIT (LNCOMMIT),
      .BDEC     (BDEC),
      .IDXW     (IDXW)
   ) u_pick (
      .br_enable    (br_enable),
      .br_pc        (br_pc),
      .br_addr      (br_addr),
      .br_short     (br_short),
      .br_dec       (br_dec),
      .commit_start (commit_start),
      .commit_kill  (commit_kill),
      .cand_v       (cand_v),
      .cand_idx     (cand_idx),
      .cand_age     (cand_age),
      .cand_pc      (cand_pc),
      .cand_short   (cand_short),
      .cand_dec     (cand_dec)
   );

   // Compare the candidate against the held entry using this cycle's ring head.
   always_comb begin
      cand_addr  = br_addr[32'(cand_idx)*LNCOMMIT +: LNCOMMIT];
      held_age   = LNCOMMIT'(age_of(32'(addr_q), 32'(commit_start), LNCOMMIT));
      held_kill  = commit_kill[addr_q];
      // Equal age means the same entry, which is never a replacement.
      cand_older = cand_v && (cand_age < held_age);
   end

   // State and held-redirect registers; reset clears everything.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
         addr_q  <= '0;
         short_q <= 1'b0;
         dec_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            pc_q    <= cand_pc;
            addr_q  <= cand_addr;
            short_q <= cand_short;
            dec_q   <= cand_dec;
         end
      end
   end

   // Next state: kill beats handshake beats replacement.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cand_v) begin
               load    = 1'b1;
               state_d = StPend;
            end
         end
         StPend: begin
            if (held_kill) begin
               // Dropping without a handshake is allowed; fetch tolerates it.
               if (cand_v) load = 1'b1;
               else        state_d = StIdle;
            end else if (redirect_ready) begin
               // A younger candidate sits on the path being flushed; discard it.
               if (cand_older) load = 1'b1;
               else            state_d = StIdle;
            end else if (cand_older) begin
               load = 1'b1;
            end
         end
      endcase
   end

   // Outputs come straight from registers.
   always_comb begin
      redirect_valid = (state_q == StPend);
      redirect_pc    = pc_q;
      redirect_addr  = addr_q;
      redirect_short = short_q;
      redirect_dec   = dec_q;
   end

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect with a queue-based scoreboard.
module tb_branch_redirect;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   br_enable;
   logic [125:0] br_pc;
   logic [9:0]   br_addr;
   logic [1:0]   br_short;
   logic [5:0]   br_dec;
   logic [4:0]   commit_start;
   logic [31:0]  commit_kill;
   logic         redirect_ready;
   logic         redirect_valid;
   logic [62:0]  redirect_pc;
   logic [4:0]   redirect_addr;
   logic         redirect_short;
   logic [2:0]   redirect_dec;

   typedef struct {
      string       name;
      logic        full;
      logic        valid;
      logic [62:0] pc;
      logic [4:0]  addr;
      logic        sh;
      logic [2:0]  dec;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   branch_redirect dut (
      .clk            (clk),
      .reset          (reset),
      .br_enable      (br_enable),
      .br_pc          (br_pc),
      .br_addr        (br_addr),
      .br_short       (br_short),
      .br_dec         (br_dec),
      .commit_start   (commit_start),
      .commit_kill    (commit_kill),
      .redirect_ready (redirect_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_addr  (redirect_addr),
      .redirect_short (redirect_short),
      .redirect_dec   (redirect_dec)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus and queue the outputs expected after the next edge.
   task automatic cyc(input string nm, input logic rst, input logic [1:0] en,
                      input logic [4:0] a0, input logic [62:0] pc0, input logic [2:0] d0,
                      input logic [4:0] a1, input logic [62:0] pc1, input logic [2:0] d1,
                      input logic [1:0] sh, input logic [4:0] cs, input logic [31:0] kill,
                      input logic rdy, input logic ev, input logic [62:0] epc,
                      input logic [4:0] ea, input logic es, input logic [2:0] ed,
                      input logic full);
      exp_t e;
      @(posedge clk);
      #1;
      reset          = rst;
      br_enable      = en;
      br_pc          = {pc1, pc0};
      br_addr        = {a1, a0};
      br_dec         = {d1, d0};
      br_short       = sh;
      commit_start   = cs;
      commit_kill    = kill;
      redirect_ready = rdy;
      e.name  = nm;
      e.full  = full;
      e.valid = ev;
      e.pc    = epc;
      e.addr  = ea;
      e.sh    = es;
      e.dec   = ed;
      q.push_back(e);
   endtask

   // Monitor: pop one expectation per edge and compare mid-cycle.
   initial begin
      exp_t       e;
      logic       prev_valid = 1'b0;
      logic [4:0] prev_addr  = '0;
      logic [4:0] prev_start = '0;
      logic [4:0] age_now, age_prev;
      forever begin
         @(posedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            checks++;
            if (redirect_valid !== e.valid) begin
               errors++;
               $display("FAIL %s valid: got %0b expected %0b", e.name, redirect_valid, e.valid);
            end
            if (e.valid || e.full) begin
               checks++;
               if (redirect_pc !== e.pc || redirect_addr !== e.addr ||
                   redirect_short !== e.sh || redirect_dec !== e.dec) begin
                  errors++;
                  $display("FAIL %s fields: got pc=%h addr=%0d short=%0b dec=%0d expected pc=%h addr=%0d short=%0b dec=%0d",
                           e.name, redirect_pc, redirect_addr, redirect_short, redirect_dec,
                           e.pc, e.addr, e.sh, e.dec);
               end
            end
            // Ring head must never move past a held redirect.
            if (redirect_valid && prev_valid && redirect_addr == prev_addr) begin
               age_now  = redirect_addr - commit_start;
               age_prev = prev_addr - prev_start;
               checks++;
               if (age_now > age_prev) begin
                  errors++;
                  $display("FAIL %s precondition: held addr=%0d age=%0d was %0d", e.name,
                           redirect_addr, age_now, age_prev);
               end
            end
            prev_valid = redirect_valid;
            prev_addr  = redirect_addr;
            prev_start = commit_start;
         end
      end
   end

   initial begin
      reset = 1'b0; br_enable = '0; br_pc = '0; br_addr = '0; br_short = '0; br_dec = '0;
      commit_start = '0; commit_kill = '0; redirect_ready = 1'b0;

      // Reset, including a strobe that must be ignored
      cyc("reset0",      0, 2'b00,  0, 63'h0,    0,  0, 63'h0,    0, 2'b00,  0, 32'h0,  0,
          0, 63'h0, 0, 0, 0, 1);
      cyc("reset_en",    0, 2'b01,  5, 63'h1000, 3,  0, 63'h0,    0, 2'b01,  0, 32'h0,  1,
          0, 63'h0, 0, 0, 0, 1);
      // Single redirect with handshake
      cyc("single_load", 1, 2'b01,  5, 63'h1000, 3,  0, 63'h0,    0, 2'b01,  0, 32'h0,  1,
          1, 63'h1000, 5, 1, 3, 0);
      cyc("single_ack",  1, 2'b00,  0, 63'h0,    0,  0, 63'h0,    0, 2'b00,  0, 32'h0,  1,
          0, 63'h0, 0, 0, 0, 0);
      // Oldest select across the ring wrap
      cyc("wrap_pick",   1, 2'b11,  2, 63'h2000, 1, 31, 63'h3100, 5, 2'b10, 30, 32'h0,  0,
          1, 63'h3100, 31, 1, 5, 0);
      cyc("wrap_hold",   1, 2'b00,  0, 63'h0,    0,  0, 63'h0,    0, 2'b00, 30, 32'h0,  0,
          1, 63'h3100, 31, 1, 5, 0);
      cyc("wrap_ack",    1, 2'b00,  0, 63'h0,    0,  0, 63'h0,    0, 2'b00, 30, 32'h0,  1,
          0, 63'h0, 0, 0, 0, 0);
      // Older replaces held, younger ignored
      cyc("held_10",     1, 2'b01, 10, 63'hA00,  1,  0, 63'h0,    0, 2'b00,  0, 32'h0,  0,
          1, 63'hA00, 10, 0, 1, 0);
      cyc("older_7",     1, 2'b10,  0, 63'h0,    0,  7, 63'h700,  2, 2'b10,  0, 32'h0,  0,
          1, 63'h700, 7, 1, 2, 0);
      cyc("younger_12",  1, 2'b01, 12, 63'hC00,  6,  0, 63'h0,    0, 2'b01,  0, 32'h0,  0,
          1, 63'h700, 7, 1, 2, 0);
      cyc("hold_7",      1, 2'b00,  0, 63'h0,    0,  0, 63'h0,    0, 2'b00,  0, 32'h0,  0,
          1, 63'h700, 7, 1, 2, 0);
      // Handshake with a simultaneous younger / older candidate
      cyc("ack_young9",  1, 2'b01,  9, 63'h900,  0,  0, 63'h0,    0, 2'b00,  0, 32'h0,  1,
          0, 63'h0, 0, 0, 0, 0);
      cyc("reload_7",    1, 2'b10,  0, 63'h0,    0,  7, 63'h700,  2, 2'b10,  0, 32'h0,  0,
          1, 63'h700, 7, 1, 2, 0);
      cyc("ack_older4",  1, 2'b01,  4, 63'h400,  6,  0, 63'h0,    0, 2'b00,  0, 32'h0,  1,
          1, 63'h400, 4, 0, 6, 0);
      cyc("ack_idle",    1, 2'b00,  0, 63'h0,    0,  0, 63'h0,    0, 2'b00,  0, 32'h0,  1,
          0, 63'h0, 0, 0, 0, 0);
      // Kill of the held entry, with and without a replacement
      cyc("reload_7b",   1, 2'b10,  0, 63'h0,    0,  7, 63'h700,  2, 2'b10,  0, 32'h0,  0,
          1, 63'h700, 7, 1, 2, 0);
      cyc("kill_7",      1, 2'b00,  0, 63'h0,    0,  0, 63'h0,    0, 2'b00,  0, 32'h80, 0,
          0, 63'h0, 0, 0, 0, 0);
      cyc("reload_7c",   1, 2'b10,  0, 63'h0,    0,  7, 63'h700,  2, 2'b10,  0, 32'h0,  0,
          1, 63'h700, 7, 1, 2, 0);
      cyc("kill_7_c3",   1, 2'b01,  3, 63'h300,  4,  0, 63'h0,    0, 2'b00,  0, 32'h80, 0,
          1, 63'h300, 3, 0, 4, 0);
      cyc("killed_c1",   1, 2'b01,  1, 63'h100,  7,  0, 63'h0,    0, 2'b01,  0, 32'h2,  0,
          1, 63'h300, 3, 0, 4, 0);
      cyc("kill_ack",    1, 2'b00,  0, 63'h0,    0,  0, 63'h0,    0, 2'b00,  0, 32'h0,  1,
          0, 63'h0, 0, 0, 0, 0);
      cyc("idle_kill6",  1, 2'b01,  6, 63'h600,  1,  0, 63'h0,    0, 2'b01,  0, 32'h40, 0,
          0, 63'h0, 0, 0, 0, 0);
      cyc("skip_killed", 1, 2'b11,  2, 63'h200,  1,  8, 63'h800,  5, 2'b10,  0, 32'h4,  0,
          1, 63'h800, 8, 1, 5, 0);
      cyc("same_entry",  1, 2'b01,  8, 63'h888,  2,  0, 63'h0,    0, 2'b01,  0, 32'h0,  0,
          1, 63'h800, 8, 1, 5, 0);
      // Reset while pending
      cyc("reset_pend",  0, 2'b01,  1, 63'h100,  1,  0, 63'h0,    0, 2'b01,  0, 32'h0,  0,
          0, 63'h0, 0, 0, 0, 1);
      cyc("post_reset",  1, 2'b00,  0, 63'h0,    0,  0, 63'h0,    0, 2'b00,  0, 32'h0,  0,
          0, 63'h0, 0, 0, 0, 1);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
